// File: rtl/frame_buffer_swap_ctrl_pkg.sv
// Shared frame geometry, controller state encoding and RGB444 field layout.
package frame_buffer_swap_ctrl_pkg;

  localparam int IMG_WIDTH    = 200;
  localparam int IMG_HEIGHT   = 160;
  localparam int FRAME_PIXELS = IMG_WIDTH * IMG_HEIGHT;
  localparam int ADDR_W       = 15;

  // RGB444 packed as ----RRRRGGGGBBBB
  localparam int RGB_R_MSB = 11;
  localparam int RGB_R_LSB = 8;
  localparam int RGB_G_MSB = 7;
  localparam int RGB_G_LSB = 4;
  localparam int RGB_B_MSB = 3;
  localparam int RGB_B_LSB = 0;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CAPTURE   = 2'd1,
    WAIT_SWAP = 2'd2
  } state_t;

endpackage

// File: rtl/frame_buffer_swap_ctrl_sat_counter8.sv
// 8-bit event counter that sticks at 255 instead of wrapping.
module sat_counter8 (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  output logic [7:0] count
);

  // Count one event per cycle of inc, holding at the top value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 8'd0;
    end else if (inc && (count != 8'hFF)) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/frame_buffer_swap_ctrl.sv
// Ping-pong frame buffer controller: camera writes one bank while VGA reads
// the other; banks swap only on a VGA vsync falling edge after a full frame.
//
//   state     | meaning
//   IDLE      | waiting for camera frame start, pixels ignored
//   CAPTURE   | writing camera pixels into wr_bank
//   WAIT_SWAP | frame complete, waiting for VGA vsync to hand it over
module frame_buffer_swap_ctrl
  import frame_buffer_swap_ctrl_pkg::*;
#(
  parameter int IMG_WIDTH  = frame_buffer_swap_ctrl_pkg::IMG_WIDTH,
  parameter int IMG_HEIGHT = frame_buffer_swap_ctrl_pkg::IMG_HEIGHT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cam_vsync,
  input  logic              cam_pixel_valid,
  input  logic [15:0]       cam_pixel_data,
  input  logic              vga_vs,
  output logic              wr_en,
  output logic [ADDR_W:0]   wr_addr,
  output logic [15:0]       wr_data,
  output logic              rd_bank,
  output logic [7:0]        frame_cnt,
  output logic [7:0]        drop_cnt,
  output logic [7:0]        short_cnt
);

  localparam int NUM_PIXELS = IMG_WIDTH * IMG_HEIGHT;
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NUM_PIXELS - 1);

  state_t            state;
  logic              wr_bank;
  logic [ADDR_W-1:0] pix_cnt;
  logic              cam_vsync_d;
  logic              vga_vs_d;
  logic              cam_start;
  logic              swap_evt;
  logic              short_inc;
  logic              drop_inc;

  // Edges against the registered previous level; delays reset high so a
  // line already high at reset release is not seen as an edge.
  assign cam_start = cam_vsync & ~cam_vsync_d;
  assign swap_evt  = ~vga_vs & vga_vs_d;

  // Restart mid-capture counts as short; frame start while a finished frame
  // is still waiting counts as dropped unless the swap lands the same cycle.
  assign short_inc = (state == CAPTURE) && cam_start;
  assign drop_inc  = (state == WAIT_SWAP) && cam_start && !swap_evt;

  // Main sequencer: edge history, capture addressing and bank ownership.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      wr_bank     <= 1'b1;
      rd_bank     <= 1'b0;
      pix_cnt     <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      frame_cnt   <= 8'd0;
      cam_vsync_d <= 1'b1;
      vga_vs_d    <= 1'b1;
    end else begin
      cam_vsync_d <= cam_vsync;
      vga_vs_d    <= vga_vs;
      wr_en       <= 1'b0;
      case (state)
        IDLE: begin
          if (cam_start) begin
            pix_cnt <= '0;
            state   <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (cam_start) begin
            // Restart on the same bank; a coincident pixel becomes index 0.
            if (cam_pixel_valid) begin
              wr_en   <= 1'b1;
              wr_addr <= {wr_bank, {ADDR_W{1'b0}}};
              wr_data <= cam_pixel_data;
              pix_cnt <= ADDR_W'(1);
            end else begin
              pix_cnt <= '0;
            end
          end else if (cam_pixel_valid) begin
            wr_en   <= 1'b1;
            wr_addr <= {wr_bank, pix_cnt};
            wr_data <= cam_pixel_data;
            if (pix_cnt == LAST_PIX) begin
              pix_cnt <= '0;
              state   <= WAIT_SWAP;
            end else begin
              pix_cnt <= pix_cnt + ADDR_W'(1);
            end
          end
        end
        WAIT_SWAP: begin
          if (swap_evt) begin
            rd_bank   <= wr_bank;
            wr_bank   <= ~wr_bank;
            frame_cnt <= frame_cnt + 8'd1;
            pix_cnt   <= '0;
            state     <= cam_start ? CAPTURE : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sat_counter8 u_drop_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (drop_inc),
    .count (drop_cnt)
  );

  sat_counter8 u_short_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (short_inc),
    .count (short_cnt)
  );

endmodule
